// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage carrying one instruction payload, with an optional
// 2-entry skid buffer that keeps in_ready_o registered at full throughput.
module pipe_stage_skid #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    RD_WIDTH   = 5,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013,
    parameter int                    SKID       = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    input  logic [DATA_WIDTH-1:0] op1_data_i,
    input  logic [DATA_WIDTH-1:0] op2_data_i,
    input  logic [RD_WIDTH-1:0]   rd_addr_i,
    input  logic                  wen_ram_i,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    output logic [DATA_WIDTH-1:0] op1_data_o,
    output logic [DATA_WIDTH-1:0] op2_data_o,
    output logic [RD_WIDTH-1:0]   rd_addr_o,
    output logic                  wen_ram_o,
    output logic [1:0]            occupancy_o
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] op1;
        logic [DATA_WIDTH-1:0] op2;
        logic [RD_WIDTH-1:0]   rd;
        logic                  wen;
    } beat_t;

    beat_t in_beat;
    beat_t main_q;
    logic  main_valid_q;
    logic  main_valid_d;
    logic  skid_valid_q;
    logic  load_main_in;
    logic  accept;
    logic  pop;

    assign in_beat = {instr_i, instr_addr_i, op1_data_i, op2_data_i, rd_addr_i, wen_ram_i};
    assign accept  = in_valid_i && in_ready_o;
    assign pop     = main_valid_q && out_ready_i;

    if (SKID != 0) begin : g_skid
        beat_t skid_q;
        logic  skid_valid_d;
        logic  load_main_skid;
        logic  load_skid;
        logic  ready_q;

        // NOTE: every variable gets a default before any branch so no latch is inferred.
        always_comb begin
            main_valid_d   = main_valid_q;
            skid_valid_d   = skid_valid_q;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
            if (skid_valid_q) begin
                // in_ready_o is low here, so only the skid-to-main move can happen
                if (pop) begin
                    load_main_skid = 1'b1;
                    skid_valid_d   = 1'b0;
                end
            end else if (!main_valid_q || pop) begin
                main_valid_d = accept;
                load_main_in = accept;
            end else if (accept) begin
                skid_valid_d = 1'b1;
                load_skid    = 1'b1;
            end
            if (flush_i) begin
                main_valid_d = 1'b0;
                skid_valid_d = 1'b0;
            end
        end

        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                main_valid_q <= 1'b0;
                skid_valid_q <= 1'b0;
                ready_q      <= 1'b1;
            end else begin
                main_valid_q <= main_valid_d;
                skid_valid_q <= skid_valid_d;
                ready_q      <= !skid_valid_d;
            end
        end

        // NOTE: payload registers are deliberately not reset; the valid bits gate every use of them.
        always_ff @(posedge clk) begin
            if (load_main_in) begin
                main_q <= in_beat;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_beat;
            end
        end

        assign in_ready_o = ready_q;
    end else begin : g_single
        always_comb begin
            main_valid_d = main_valid_q;
            load_main_in = accept;
            if (accept) begin
                main_valid_d = 1'b1;
            end else if (pop) begin
                main_valid_d = 1'b0;
            end
            if (flush_i) begin
                main_valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                main_valid_q <= 1'b0;
            end else begin
                main_valid_q <= main_valid_d;
            end
        end

        always_ff @(posedge clk) begin
            if (load_main_in) begin
                main_q <= in_beat;
            end
        end

        assign skid_valid_q = 1'b0;
        assign in_ready_o   = !main_valid_q || out_ready_i;
    end

    // An empty stage presents a NOP bubble regardless of stale register contents.
    always_comb begin
        instr_o      = NOP_INSTR;
        instr_addr_o = '0;
        op1_data_o   = '0;
        op2_data_o   = '0;
        rd_addr_o    = '0;
        wen_ram_o    = 1'b0;
        if (main_valid_q) begin
            instr_o      = main_q.instr;
            instr_addr_o = main_q.addr;
            op1_data_o   = main_q.op1;
            op2_data_o   = main_q.op2;
            rd_addr_o    = main_q.rd;
            wen_ram_o    = main_q.wen;
        end
    end

    assign out_valid_o = main_valid_q;
    assign occupancy_o = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a SKID=1 instance with directed vectors
// and a SKID=0 instance with random handshakes, both checked against FIFO queues.
module tb_pipe_stage_skid;

    typedef struct packed {
        logic [31:0] instr;
        logic [11:0] addr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        wen;
    } beat_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // SKID=1 instance signals
    logic        s_in_valid = 1'b0, s_out_ready = 1'b0, s_flush = 1'b0;
    beat_t       s_din = '0;
    logic        s_in_ready, s_out_valid, s_wen_o;
    logic [31:0] s_instr_o, s_op1_o, s_op2_o;
    logic [11:0] s_addr_o;
    logic [4:0]  s_rd_o;
    logic [1:0]  s_occ;

    // SKID=0 instance signals
    logic        n_in_valid = 1'b0, n_out_ready = 1'b0, n_flush = 1'b0;
    beat_t       n_din = '0;
    logic        n_in_ready, n_out_valid, n_wen_o;
    logic [31:0] n_instr_o, n_op1_o, n_op2_o;
    logic [11:0] n_addr_o;
    logic [4:0]  n_rd_o;
    logic [1:0]  n_occ;

    pipe_stage_skid #(.SKID(1)) u_skid (
        .clk(clk), .rstn(rstn),
        .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
        .instr_i(s_din.instr), .instr_addr_i(s_din.addr),
        .op1_data_i(s_din.op1), .op2_data_i(s_din.op2),
        .rd_addr_i(s_din.rd), .wen_ram_i(s_din.wen),
        .flush_i(s_flush),
        .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
        .instr_o(s_instr_o), .instr_addr_o(s_addr_o),
        .op1_data_o(s_op1_o), .op2_data_o(s_op2_o),
        .rd_addr_o(s_rd_o), .wen_ram_o(s_wen_o),
        .occupancy_o(s_occ)
    );

    pipe_stage_skid #(.SKID(0)) u_single (
        .clk(clk), .rstn(rstn),
        .in_valid_i(n_in_valid), .in_ready_o(n_in_ready),
        .instr_i(n_din.instr), .instr_addr_i(n_din.addr),
        .op1_data_i(n_din.op1), .op2_data_i(n_din.op2),
        .rd_addr_i(n_din.rd), .wen_ram_i(n_din.wen),
        .flush_i(n_flush),
        .out_valid_o(n_out_valid), .out_ready_i(n_out_ready),
        .instr_o(n_instr_o), .instr_addr_o(n_addr_o),
        .op1_data_o(n_op1_o), .op2_data_o(n_op2_o),
        .rd_addr_o(n_rd_o), .wen_ram_o(n_wen_o),
        .occupancy_o(n_occ)
    );

    beat_t s_q[$];
    beat_t n_q[$];
    int    s_pops = 0;
    int    n_pops = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic beat_t make_beat(input logic [31:0] tag);
        beat_t b;
        b.instr = tag;
        b.addr  = tag[11:0] ^ 12'hA5A;
        b.op1   = tag * 3 + 1;
        b.op2   = ~tag;
        b.rd    = tag[4:0] ^ 5'h15;
        b.wen   = tag[0] ^ tag[4];
        return b;
    endfunction

    function automatic beat_t s_got();
        return {s_instr_o, s_addr_o, s_op1_o, s_op2_o, s_rd_o, s_wen_o};
    endfunction

    function automatic beat_t n_got();
        return {n_instr_o, n_addr_o, n_op1_o, n_op2_o, n_rd_o, n_wen_o};
    endfunction

    // Monitors: compare every downstream pop against the head of the expected queue.
    always @(negedge clk) begin
        if (rstn && s_out_valid && s_out_ready) begin
            if (s_q.size() == 0) begin
                check("skid_unexpected_beat", 128'(s_q.size()), 128'(1));
            end else begin
                check("skid_out_beat", 128'(s_got()), 128'(s_q.pop_front()));
                s_pops++;
            end
        end
    end

    always @(negedge clk) begin
        if (rstn && n_out_valid && n_out_ready) begin
            if (n_q.size() == 0) begin
                check("single_unexpected_beat", 128'(n_q.size()), 128'(1));
            end else begin
                check("single_out_beat", 128'(n_got()), 128'(n_q.pop_front()));
                n_pops++;
            end
        end
    end

    // One cycle of SKID=1 stimulus; returns after the edge with outputs settled.
    task automatic s_step(input logic v, input logic [31:0] tag, input logic rdy,
                          input logic fl, output logic acc);
        s_in_valid  = v;
        s_din       = make_beat(tag);
        s_out_ready = rdy;
        s_flush     = fl;
        @(negedge clk);
        #1;
        acc = v && s_in_ready;
        if (fl) s_q.delete();
        else if (acc) s_q.push_back(make_beat(tag));
        @(posedge clk);
        #1;
    endtask

    task automatic n_step(input logic v, input logic [31:0] tag, input logic rdy,
                          output logic acc);
        n_in_valid  = v;
        n_din       = make_beat(tag);
        n_out_ready = rdy;
        @(negedge clk);
        #1;
        check("single_ready_comb", 128'(n_in_ready), 128'(!n_out_valid || n_out_ready));
        check("single_occupancy", 128'(n_occ), 128'({1'b0, n_out_valid}));
        acc = v && n_in_ready;
        if (acc) n_q.push_back(make_beat(tag));
        @(posedge clk);
        #1;
    endtask

    task automatic s_expect(input string name, input logic ov, input logic ir, input logic [1:0] occ);
        check({name, "_out_valid"}, 128'(s_out_valid), 128'(ov));
        check({name, "_in_ready"}, 128'(s_in_ready), 128'(ir));
        check({name, "_occupancy"}, 128'(s_occ), 128'(occ));
    endtask

    task automatic s_expect_bubble(input string name);
        check({name, "_nop_instr"}, 128'(s_instr_o), 128'(32'h0000_0013));
        check({name, "_zero_fields"}, 128'({s_addr_o, s_op1_o, s_op2_o, s_rd_o, s_wen_o}), 128'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        acc;
        logic [31:0] tag;
        int          n_acc;
        int          pops_before;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        s_expect("por", 1'b0, 1'b1, 2'd0);
        s_expect_bubble("por");
        rstn = 1'b1;

        // Mid-cycle reset with a held beat and arbitrary inputs
        s_step(1'b1, 32'h0F0, 1'b0, 1'b0, acc);
        check("prefill_instr", 128'(s_instr_o), 128'(32'h0F0));
        #2;
        rstn        = 1'b0;
        s_in_valid  = 1'b1;
        s_din       = make_beat(32'hDEAD_BEEF);
        s_out_ready = 1'b1;
        n_in_valid  = 1'b1;
        n_din       = make_beat(32'hCAFE_F00D);
        #1;
        s_expect("async_reset", 1'b0, 1'b1, 2'd0);
        s_expect_bubble("async_reset");
        check("single_reset_valid", 128'(n_out_valid), 128'(0));
        check("single_reset_ready", 128'(n_in_ready), 128'(1));
        check("single_reset_instr", 128'(n_instr_o), 128'(32'h0000_0013));
        s_q.delete();
        n_q.delete();
        n_in_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Streaming at full rate: 1-cycle latency, no bubbles
        for (int i = 0; i < 8; i++) begin
            s_step(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0, acc);
            check("stream_accept", 128'(acc), 128'(1));
            check("stream_latency_instr", 128'(s_instr_o), 128'(32'h100 + 32'(i)));
            s_expect("stream", 1'b1, 1'b1, 2'd1);
        end
        s_step(1'b0, 32'h0, 1'b1, 1'b0, acc);
        s_expect("stream_drained", 1'b0, 1'b1, 2'd0);
        s_expect_bubble("stream_drained");

        // Back-pressure: 3-cycle stall with continuous upstream traffic
        tag   = 32'h200;
        n_acc = 0;
        for (int k = 0; k < 3; k++) begin
            s_step(1'b1, tag, 1'b0, 1'b0, acc);
            if (acc) begin
                tag++;
                n_acc++;
            end
            if (k == 1) s_expect("skid_filled", 1'b1, 1'b0, 2'd2);
        end
        check("stall_accept_count", 128'(n_acc), 128'(2));
        s_expect("stalled", 1'b1, 1'b0, 2'd2);
        check("stalled_head", 128'(s_instr_o), 128'(32'h200));
        s_out_ready = 1'b1;
        #1;
        check("ready_not_combinational", 128'(s_in_ready), 128'(0));
        s_step(1'b1, tag, 1'b1, 1'b0, acc);
        check("drain_no_accept", 128'(acc), 128'(0));
        s_expect("skid_drained", 1'b1, 1'b1, 2'd1);
        check("drain_head", 128'(s_instr_o), 128'(32'h201));
        while (tag < 32'h204) begin
            s_step(1'b1, tag, 1'b1, 1'b0, acc);
            if (acc) tag++;
        end
        check("post_stall_head", 128'(s_instr_o), 128'(32'h203));
        s_step(1'b0, 32'h0, 1'b1, 1'b0, acc);
        check("backpressure_all_delivered", 128'(s_q.size()), 128'(0));
        s_expect("backpressure_empty", 1'b0, 1'b1, 2'd0);

        // Flush with two held beats while 0x2AA is offered
        s_step(1'b1, 32'h300, 1'b0, 1'b0, acc);
        s_step(1'b1, 32'h301, 1'b0, 1'b0, acc);
        s_expect("flush_pre", 1'b1, 1'b0, 2'd2);
        s_step(1'b1, 32'h2AA, 1'b0, 1'b1, acc);
        s_expect("flush_full", 1'b0, 1'b1, 2'd0);
        s_expect_bubble("flush_full");
        // Flush that swallows a completed accept
        s_step(1'b1, 32'h302, 1'b0, 1'b0, acc);
        s_step(1'b1, 32'h2AA, 1'b0, 1'b1, acc);
        check("flush_accept_completes", 128'(acc), 128'(1));
        s_expect("flush_accept", 1'b0, 1'b1, 2'd0);
        pops_before = s_pops;
        s_step(1'b0, 32'h0, 1'b1, 1'b0, acc);
        s_step(1'b0, 32'h0, 1'b1, 1'b0, acc);
        check("flushed_beat_never_out", 128'(s_pops), 128'(pops_before));
        check("flushed_stays_empty", 128'(s_out_valid), 128'(0));

        // Flush concurrent with a pop
        s_step(1'b1, 32'h400, 1'b1, 1'b0, acc);
        pops_before = s_pops;
        s_step(1'b0, 32'h0, 1'b1, 1'b1, acc);
        check("flush_pop_counted_once", 128'(s_pops), 128'(pops_before + 1));
        s_expect("flush_pop", 1'b0, 1'b1, 2'd0);

        // Flush held for two cycles with incoming traffic
        for (int k = 0; k < 2; k++) begin
            s_step(1'b1, 32'h500 + 32'(k), 1'b1, 1'b1, acc);
            s_expect("flush_held", 1'b0, 1'b1, 2'd0);
        end
        s_step(1'b1, 32'h600, 1'b1, 1'b0, acc);
        check("recover_instr", 128'(s_instr_o), 128'(32'h600));
        s_step(1'b0, 32'h0, 1'b1, 1'b0, acc);
        check("skid_queue_empty", 128'(s_q.size()), 128'(0));
        s_flush = 1'b0;
        s_in_valid = 1'b0;

        // SKID=0: random handshakes against the reference queue
        tag   = 32'h1000;
        n_acc = 0;
        for (int c = 0; c < 1000; c++) begin
            n_step(1'($urandom_range(0, 1)), tag, 1'($urandom_range(0, 1)), acc);
            if (acc) begin
                tag++;
                n_acc++;
            end
        end
        for (int c = 0; c < 3; c++) n_step(1'b0, 32'h0, 1'b1, acc);
        check("single_queue_empty", 128'(n_q.size()), 128'(0));
        check("single_no_loss", 128'(n_pops), 128'(n_acc));
        check("single_empty_after_drain", 128'(n_out_valid), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
